fxp_divider: RTL and testbench
==============================

FXP_DIVIDER -- requirements
Module: fxp_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result word width in bits.
REQ-002 The block SHALL have parameter FRAC_BITS, default 10, giving the fractional bits of the signed two's-complement Q format.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a division, sampled only in IDLE.
REQ-006 The block SHALL have port A, input, WIDTH bits: signed dividend, captured on the accepting edge.
REQ-007 The block SHALL have port B, input, WIDTH bits: signed divisor, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the accepting edge until done is asserted.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result and flags valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: signed quotient A/B, same Q format, held until the next accepted start.
REQ-011 The block SHALL have port overflow_flag, output, 1 bit: quotient not representable in WIDTH bits, valid with done.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: B was zero, valid with done.

Function
REQ-013 The block SHALL implement states IDLE, CALC, FIX and DONE, moving IDLE->CALC on start, CALC->FIX after WIDTH+FRAC_BITS iterations, FIX->DONE, and DONE->IDLE unconditionally.
REQ-014 On acceptance the block SHALL latch the magnitudes of A and B and the quotient sign (A[MSB] xor B[MSB]); operand changes after acceptance have no effect.
REQ-015 CALC SHALL run restoring division of the |A| << FRAC_BITS numerator by |B|, one quotient bit per cycle, MSB first, with WIDTH+FRAC_BITS quotient bits.
REQ-016 The quotient SHALL truncate toward zero; no rounding.
REQ-017 FIX SHALL apply the sign and detect overflow: magnitude > 2^(WIDTH-1)-1 when positive, or > 2^(WIDTH-1) when negative.
REQ-018 done SHALL be high exactly WIDTH+FRAC_BITS+2 cycles after the accepting edge, which is 28 cycles for the defaults, for exactly one cycle.
REQ-019 busy SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-020 start asserted while not in IDLE SHALL be ignored; start high in DONE is not accepted until the following IDLE cycle.
REQ-021 For B = 0, CALC SHALL still run full length, and at done div_by_zero=1, overflow_flag=1, result = 0x7FFF if A >= 0 else 0x8000, with or without the macro.
REQ-022 For A = 0x8000 with the defaults, magnitude 32768 SHALL be handled without internal overflow.

Reset
REQ-023 While rst is high, the block SHALL be forced into IDLE with busy=0, done=0, result=0, overflow_flag=0 and div_by_zero=0, immediately and independent of clk.
REQ-024 Reset during CALC or FIX SHALL abandon the operation with no done pulse; a start on the first edge after release SHALL be accepted normally.

Configuration
REQ-025 With macro FXP_DIV_SATURATE_EN defined, an overflowing result SHALL be clamped to 0x7FFF (positive) or 0x8000 (negative) for the defaults.
REQ-026 Without FXP_DIV_SATURATE_EN, an overflowing result SHALL be the low WIDTH bits of the signed quotient; overflow_flag behaves identically in both builds.

Verification
REQ-027 The bench SHALL apply A=0x1800, B=0x0800 (6.0/2.0) and check result=0x0C00, overflow_flag=0, div_by_zero=0, with done 28 cycles after start.
REQ-028 The bench SHALL apply A=0xF400, B=0x0600 (-3.0/1.5) and check result=0xF800, overflow_flag=0.
REQ-029 The bench SHALL apply A=0x4000, B=0x0100 (16/0.25) and check overflow_flag=1, with result=0x7FFF when FXP_DIV_SATURATE_EN is defined and 0x0000 when it is not.
REQ-030 The bench SHALL apply A=0xFC00, B=0x0000 and check div_by_zero=1, overflow_flag=1, result=0x8000.
REQ-031 The bench SHALL apply start with A=0x0400, B=0x0800, pulse start again with other operands at cycle 5, and check only one done at cycle 28 with result=0x0200.
REQ-032 The bench SHALL assert rst at cycle 10 of a division and check outputs zero immediately, no done, then a fresh division completing correctly.

Source files
------------

// File: rtl/fxp_divider.sv
// Signed fixed-point divider: restoring division, one quotient bit per clock.
// Define FXP_DIV_SATURATE_EN to clamp overflowing quotients instead of wrapping them.
module fxp_divider #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     LIM_POS = {{FRAC_BITS{1'b0}}, MAX_POS};
  localparam logic [N-1:0]     LIM_NEG = {{FRAC_BITS{1'b0}}, MIN_NEG};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     num_q;    // numerator bits shift out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic             a_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             q_bit;
  logic [WIDTH-1:0] rem_d;
  logic [N-1:0]     num_d;
  logic [WIDTH-1:0] mag_lo;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             dbz_d;

  // Unsigned magnitudes; the most negative operand maps to 2^(WIDTH-1), which still fits.
  assign a_mag = A[WIDTH-1] ? (~A) + WIDTH'(1) : A;
  assign b_mag = B[WIDTH-1] ? (~B) + WIDTH'(1) : B;

  // One restoring step: the remainder stays below the divisor, so WIDTH bits suffice after subtraction.
  always_comb begin
    rem_shift = {rem_q, num_q[N-1]};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    rem_d     = q_bit ? rem_shift[WIDTH-1:0] - dvs_q : rem_shift[WIDTH-1:0];
    num_d     = {num_q[N-2:0], q_bit};
  end

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    mag_lo = num_q[WIDTH-1:0];
    dbz_d  = (dvs_q == '0);
    ovf_d  = neg_q ? (num_q > LIM_NEG) : (num_q > LIM_POS);
    res_d  = neg_q ? (~mag_lo) + WIDTH'(1) : mag_lo;
    if (dbz_d) begin
      ovf_d = 1'b1;
      res_d = a_neg_q ? MIN_NEG : MAX_POS;
    end else if (ovf_d) begin
`ifdef FXP_DIV_SATURATE_EN
      res_d = neg_q ? MIN_NEG : MAX_POS;
`else
      res_d = neg_q ? (~mag_lo) + WIDTH'(1) : mag_lo;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q   <= {a_mag, {FRAC_BITS{1'b0}}};
            rem_q   <= '0;
            dvs_q   <= b_mag;
            neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
            a_neg_q <= A[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          num_q <= num_d;
          rem_q <= rem_d;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          dbz_q    <= dbz_d;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Self-checking bench for fxp_divider: directed vector table, random operands against
// an arithmetic reference model, and hand-written sequences for start/reset corner cases.
module tb_fxp_divider;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 10;
  localparam int LAT       = WIDTH + FRAC_BITS + 2;
`ifdef FXP_DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        busy, done, overflow_flag, div_by_zero;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  fxp_divider #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .A             (A),
    .B             (B),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .overflow_flag (overflow_flag),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: exact integer division of |A|*2^FRAC_BITS by |B|, truncated, then signed.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic ovf, output logic dbz);
    longint sa, sb, mag, q;
    bit neg;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = (sb == 0);
    if (dbz) begin
      ovf = 1'b1;
      res = (sa < 0) ? 16'h8000 : 16'h7FFF;
      return;
    end
    neg = (sa < 0) != (sb < 0);
    mag = ((sa < 0 ? -sa : sa) * (longint'(1) << FRAC_BITS)) / (sb < 0 ? -sb : sb);
    ovf = neg ? (mag > 32768) : (mag > 32767);
    q   = neg ? -mag : mag;
    if (ovf && SAT) res = neg ? 16'h8000 : 16'h7FFF;
    else            res = q[15:0];
  endfunction

  // Starts a division from IDLE and returns outputs seen with done, plus done latency in edges.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic ovf, output logic dbz, output int lat);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy after accept", 32'(busy), 32'(1));
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result; ovf = overflow_flag; dbz = div_by_zero;
    @(posedge clk); #1;
    check("done single cycle", 32'(done), 32'(0));
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        dbz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  logic [15:0] r, er, a_r, b_r, r1, r2;
  logic        o, z, eo, ez;
  int          lat, ndone, first_done, second_done;

  initial begin
    vecs[0]  = '{"6.0/2.0",    16'h1800, 16'h0800, 16'h0C00, 1'b0, 1'b0};
    vecs[1]  = '{"-3.0/1.5",   16'hF400, 16'h0600, 16'hF800, 1'b0, 1'b0};
    vecs[2]  = '{"16/0.25",    16'h4000, 16'h0100, SAT ? 16'h7FFF : 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{"-1/0",       16'hFC00, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[4]  = '{"0/0",        16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{"-32/1",      16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0};
    vecs[6]  = '{"-32/-1",     16'h8000, 16'hFC00, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0};
    vecs[7]  = '{"max/1",      16'h7FFF, 16'h0400, 16'h7FFF, 1'b0, 1'b0};
    vecs[8]  = '{"1.25/0.75",  16'h0500, 16'h0300, 16'h06AA, 1'b0, 1'b0};
    vecs[9]  = '{"-1.25/0.75", 16'hFB00, 16'h0300, 16'hF956, 1'b0, 1'b0};
    vecs[10] = '{"lsb/max",    16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{"-lsb/2",     16'hFFFF, 16'h0800, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{"-32/0.5",    16'h8000, 16'h0200, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",     32'(busy),          32'(0));
    check("reset done",     32'(done),          32'(0));
    check("reset result",   32'(result),        32'(0));
    check("reset overflow", 32'(overflow_flag), 32'(0));
    check("reset dbz",      32'(div_by_zero),   32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_div(vecs[i].a, vecs[i].b, r, o, z, lat);
      check({vecs[i].name, " latency"},  32'(lat), 32'(LAT));
      check({vecs[i].name, " result"},   32'(r),   32'(vecs[i].res));
      check({vecs[i].name, " overflow"}, 32'(o),   32'(vecs[i].ovf));
      check({vecs[i].name, " dbz"},      32'(z),   32'(vecs[i].dbz));
    end

    for (int i = 0; i < 40; i++) begin
      a_r = 16'($urandom);
      if (i % 8 == 0)      b_r = 16'h0000;
      else if (i % 3 == 0) b_r = 16'($urandom_range(1, 255));
      else                 b_r = 16'($urandom);
      model(a_r, b_r, er, eo, ez);
      do_div(a_r, b_r, r, o, z, lat);
      check($sformatf("rand %h/%h latency", a_r, b_r),  32'(lat), 32'(LAT));
      check($sformatf("rand %h/%h result", a_r, b_r),   32'(r),   32'(er));
      check($sformatf("rand %h/%h overflow", a_r, b_r), 32'(o),   32'(eo));
      check($sformatf("rand %h/%h dbz", a_r, b_r),      32'(z),   32'(ez));
    end

    // Start pulses while busy and while in DONE must be ignored; held start is taken in the next IDLE.
    A = 16'h0400; B = 16'h0800; start = 1'b1;
    ndone = 0; first_done = -1; second_done = -1; r1 = '0; r2 = '0;
    for (int c = 0; c <= 62; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_done = c; r1 = result; end
        else if (ndone == 2) begin second_done = c; r2 = result; end
      end
      if (c == 0)  start = 1'b0;
      if (c == 4)  begin A = 16'h7000; B = 16'h0100; start = 1'b1; end
      if (c == 5)  start = 1'b0;
      if (c == 26) check("busy in FIX", 32'(busy), 32'(1));
      if (c == 27) begin
        check("busy in DONE", 32'(busy), 32'(0));
        A = 16'h0C00; B = 16'h0400; start = 1'b1;
      end
      if (c == 29) begin
        check("busy after IDLE accept", 32'(busy), 32'(1));
        start = 1'b0;
      end
    end
    check("ignored start done count", 32'(ndone),       32'(2));
    check("first done cycle",         32'(first_done),  32'(LAT));
    check("first result 1.0/2.0",     32'(r1),          32'(16'h0200));
    check("second done cycle",        32'(second_done), 32'(29 + LAT));
    check("second result 3.0/1.0",    32'(r2),          32'(16'h0C00));

    // Asynchronous reset in the middle of CALC.
    A = 16'h1800; B = 16'h0800; start = 1'b1;
    ndone = 0;
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (done) ndone++;
    end
    check("busy before reset", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("async reset busy",     32'(busy),          32'(0));
    check("async reset done",     32'(done),          32'(0));
    check("async reset result",   32'(result),        32'(0));
    check("async reset overflow", 32'(overflow_flag), 32'(0));
    check("async reset dbz",      32'(div_by_zero),   32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    A = 16'hF400; B = 16'h0600; start = 1'b1;
    first_done = -1; r1 = '0; o = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done < 0) begin first_done = c; r1 = result; o = overflow_flag; end
      end
    end
    check("post-reset done count", 32'(ndone),      32'(1));
    check("post-reset done cycle", 32'(first_done), 32'(LAT));
    check("post-reset result",     32'(r1),         32'(16'hF800));
    check("post-reset overflow",   32'(o),          32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
